// File: rtl/req_pending_server_if.sv
// Request/grant bundle for req_pending_server.
// The master side raises request pulses and consumes grants.
// The slave side is the server itself.
// CNT_W must match the CNT_W of the server that is attached to it.
interface req_pending_server_if #(
  parameter int CNT_W = 8
);

  logic [3:0]       req;
  logic             gnt_ready;
  logic             clr_lost;
  logic             gnt_valid;
  logic [1:0]       gnt_code;
  logic [3:0]       gnt_onehot;
  logic [3:0]       pend;
  logic             idle;
  logic [3:0]       lost;
  logic [CNT_W-1:0] served_cnt;

  modport master (
    output req,
    output gnt_ready,
    output clr_lost,
    input  gnt_valid,
    input  gnt_code,
    input  gnt_onehot,
    input  pend,
    input  idle,
    input  lost,
    input  served_cnt
  );

  modport slave (
    input  req,
    input  gnt_ready,
    input  clr_lost,
    output gnt_valid,
    output gnt_code,
    output gnt_onehot,
    output pend,
    output idle,
    output lost,
    output served_cnt
  );

endinterface

// File: rtl/req_pending_server.sv
// Request-serving stage built around a 4-to-2 priority encoder.
// Single-cycle request pulses are latched into sticky pending bits.
// The highest pending line (bit 3 first) is offered as a grant over valid/ready.
// Once a grant is accepted, its pending bit is retired.
// An optional gap of GAP idle cycles follows each accepted grant.
module req_pending_server #(
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  req_pending_server_if.slave  bus
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       pend_q;
  logic [3:0]       lost_q;
  logic             gnt_valid_q;
  logic [1:0]       gnt_code_q;
  logic [3:0]       gnt_onehot_q;
  logic [CNT_W-1:0] served_q;

  logic             accept;
  logic [3:0]       clr_mask;
  logic [3:0]       pend_n;
  logic [3:0]       lost_set;
  logic [1:0]       enc_code;

  // gnt_onehot_q is zero whenever no grant is valid, so it doubles as the retire mask.
  assign accept   = gnt_valid_q & bus.gnt_ready;
  assign clr_mask = accept ? gnt_onehot_q : 4'b0000;

  // A fresh request in the retire cycle re-arms the bit; it is not treated as a lost request.
  assign pend_n   = (pend_q & ~clr_mask) | bus.req;
  assign lost_set = bus.req & pend_q & ~clr_mask;

  // Priority encode: scan upward so that the highest set bit wins.
  always_comb begin
    enc_code = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (pend_q[k]) begin
        enc_code = 2'(k);
      end
    end
  end

  // Pending bits and sticky lost flags; a new lost event wins over clr_lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 4'b0000;
      lost_q <= 4'b0000;
    end else begin
      pend_q <= pend_n;
      if (bus.clr_lost) begin
        lost_q <= lost_set;
      end else begin
        lost_q <= lost_q | lost_set;
      end
    end
  end

  // Grant FSM: issue the grant, hold it until it is accepted, then pause for the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      gap_cnt      <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_code_q   <= 2'd0;
      gnt_onehot_q <= 4'b0000;
      served_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend_q != 4'b0000) begin
            state        <= S_GRANT;
            gnt_valid_q  <= 1'b1;
            gnt_code_q   <= enc_code;
            gnt_onehot_q <= 4'b0001 << enc_code;
          end
        end
        S_GRANT: begin
          if (accept) begin
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= 4'b0000;
            served_q     <= served_q + CNT_W'(1);
            if (GAP == 0) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          gnt_valid_q  <= 1'b0;
          gnt_onehot_q <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_code   = gnt_code_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.pend       = pend_q;
  assign bus.lost       = lost_q;
  assign bus.served_cnt = served_q;
  assign bus.idle       = (pend_q == 4'b0000) && (state == S_IDLE);

endmodule

// File: tb/tb_req_pending_server.sv
// Directed testbench for req_pending_server.
// Two instances share clock, reset and stimulus.
// dut uses GAP=2 and dut0 uses GAP=0.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_req_pending_server;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  req_pending_server_if #(.CNT_W(CNT_W)) bus  ();
  req_pending_server_if #(.CNT_W(CNT_W)) bus0 ();

  req_pending_server #(.GAP(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  req_pending_server #(.GAP(0), .CNT_W(CNT_W)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Drive one cycle of inputs to both instances, then return at the next falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic cl);
    bus.req        = r;
    bus.gnt_ready  = rdy;
    bus.clr_lost   = cl;
    bus0.req       = r;
    bus0.gnt_ready = rdy;
    bus0.clr_lost  = cl;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  int          rise_cyc  [8];
  logic [1:0]  rise_code [8];
  int          rise_n;
  int          rise_cyc0 [8];
  logic [1:0]  rise_code0[8];
  int          rise_n0;
  logic        prev_v;
  logic        prev_v0;
  int          exp_cnt;
  int          guard;
  logic        obs_v;

  initial begin
    rst_n = 1'b0;
    bus.req = 4'b0;  bus.gnt_ready = 1'b0;  bus.clr_lost = 1'b0;
    bus0.req = 4'b0; bus0.gnt_ready = 1'b0; bus0.clr_lost = 1'b0;
    repeat (2) @(negedge clk);

    // ---- reset state ----
    checkOutput("rst_pend",   32'(bus.pend),       32'h0);
    checkOutput("rst_lost",   32'(bus.lost),       32'h0);
    checkOutput("rst_cnt",    32'(bus.served_cnt), 32'h0);
    checkOutput("rst_valid",  32'(bus.gnt_valid),  32'h0);
    checkOutput("rst_code",   32'(bus.gnt_code),   32'h0);
    checkOutput("rst_onehot", 32'(bus.gnt_onehot), 32'h0);
    checkOutput("rst_idle",   32'(bus.idle),       32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- two requests, GAP=2 ----
    applyStimulus(4'b0110, 1'b1, 1'b0);
    checkOutput("t1_pend",    32'(bus.pend),       32'h6);
    checkOutput("t1_valid0",  32'(bus.gnt_valid),  32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t1_valid",   32'(bus.gnt_valid),  32'h1);
    checkOutput("t1_code2",   32'(bus.gnt_code),   32'h2);
    checkOutput("t1_oh2",     32'(bus.gnt_onehot), 32'h4);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t1_acc_v",   32'(bus.gnt_valid),  32'h0);
    checkOutput("t1_acc_p",   32'(bus.pend),       32'h2);
    checkOutput("t1_cnt1",    32'(bus.served_cnt), 32'h1);
    checkOutput("t1_oh_off",  32'(bus.gnt_onehot), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t1_gap_a",   32'(bus.gnt_valid),  32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t1_gap_b",   32'(bus.gnt_valid),  32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t1_valid2",  32'(bus.gnt_valid),  32'h1);
    checkOutput("t1_code1",   32'(bus.gnt_code),   32'h1);
    checkOutput("t1_oh1",     32'(bus.gnt_onehot), 32'h2);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t1_cnt2",    32'(bus.served_cnt), 32'h2);
    checkOutput("t1_pend0",   32'(bus.pend),       32'h0);
    checkOutput("t1_busy",    32'(bus.idle),       32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t1_idle",    32'(bus.idle),       32'h1);

    // ---- all four lines: order and spacing for GAP=2 and GAP=0 ----
    rise_n = 0; rise_n0 = 0; prev_v = 1'b0; prev_v0 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus((i == 0) ? 4'b1111 : 4'b0000, 1'b1, 1'b0);
      if (bus.gnt_valid && !prev_v && rise_n < 8) begin
        rise_cyc[rise_n] = i; rise_code[rise_n] = bus.gnt_code; rise_n++;
      end
      if (bus0.gnt_valid && !prev_v0 && rise_n0 < 8) begin
        rise_cyc0[rise_n0] = i; rise_code0[rise_n0] = bus0.gnt_code; rise_n0++;
      end
      prev_v  = bus.gnt_valid;
      prev_v0 = bus0.gnt_valid;
    end
    checkOutput("t2_grants",  32'(rise_n),  32'd4);
    checkOutput("t2_grants0", 32'(rise_n0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_code%0d", k),  32'(rise_code[k]),  32'(3 - k));
      checkOutput($sformatf("t2_code0_%0d", k), 32'(rise_code0[k]), 32'(3 - k));
    end
    for (int k = 1; k < 4; k++) begin
      checkOutput($sformatf("t2_space%0d", k),  32'(rise_cyc[k] - rise_cyc[k-1]),   32'd4);
      checkOutput($sformatf("t2_space0_%0d", k), 32'(rise_cyc0[k] - rise_cyc0[k-1]), 32'd2);
    end
    checkOutput("t2_cnt",     32'(bus.served_cnt),  32'd6);
    checkOutput("t2_cnt0",    32'(bus0.served_cnt), 32'd6);
    checkOutput("t2_lost",    32'(bus.lost),        32'h0);
    checkOutput("t2_idle",    32'(bus.idle),        32'h1);

    // ---- no preemption while a grant is held ----
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("t3_pend",    32'(bus.pend),       32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_code0",   32'(bus.gnt_code),   32'h0);
    checkOutput("t3_oh0",     32'(bus.gnt_onehot), 32'h1);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("t3_pend9",   32'(bus.pend),       32'h9);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_hold_v",  32'(bus.gnt_valid),  32'h1);
    checkOutput("t3_hold_c",  32'(bus.gnt_code),   32'h0);
    checkOutput("t3_hold_oh", 32'(bus.gnt_onehot), 32'h1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t3_acc_p",   32'(bus.pend),       32'h8);
    checkOutput("t3_cnt7",    32'(bus.served_cnt), 32'd7);
    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_next_v",  32'(bus.gnt_valid),  32'h1);
    checkOutput("t3_code3",   32'(bus.gnt_code),   32'h3);
    checkOutput("t3_oh3",     32'(bus.gnt_onehot), 32'h8);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t3_cnt8",    32'(bus.served_cnt), 32'd8);
    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_idle",    32'(bus.idle),       32'h1);

    // ---- lost flags ----
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t4_nolost",  32'(bus.lost),       32'h0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t4_lost",    32'(bus.lost),       32'h4);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("t4_clr",     32'(bus.lost),       32'h0);
    checkOutput("t4_gnt2",    32'(bus.gnt_code),   32'h2);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("t4_rearm",   32'(bus.pend),       32'h4);
    checkOutput("t4_lost0",   32'(bus.lost),       32'h0);
    checkOutput("t4_cnt9",    32'(bus.served_cnt), 32'd9);
    applyStimulus(4'b0100, 1'b0, 1'b1);
    checkOutput("t4_setwins", 32'(bus.lost),       32'h4);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("t4_clr2",    32'(bus.lost),       32'h0);
    guard = 0;
    while (!bus.idle && guard < 20) begin
      applyStimulus(4'b0000, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("t4_drain",   32'(bus.idle),       32'h1);
    checkOutput("t4_cnt10",   32'(bus.served_cnt), 32'd10);

    // ---- asynchronous reset in the middle of a grant ----
    applyStimulus(4'b1010, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t5_pre_v",   32'(bus.gnt_valid),  32'h1);
    checkOutput("t5_pre_c",   32'(bus.gnt_code),   32'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_v",   32'(bus.gnt_valid),  32'h0);
    checkOutput("t5_rst_p",   32'(bus.pend),       32'h0);
    checkOutput("t5_rst_cnt", 32'(bus.served_cnt), 32'h0);
    checkOutput("t5_rst_oh",  32'(bus.gnt_onehot), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput($sformatf("t5_quiet_v%0d", i), 32'(bus.gnt_valid), 32'h0);
      checkOutput($sformatf("t5_quiet_i%0d", i), 32'(bus.idle),      32'h1);
    end

    // ---- served counter wraps after 256 grants ----
    exp_cnt = 0;
    guard   = 0;
    while (exp_cnt != 255 && guard < 2000) begin
      obs_v = bus.gnt_valid;
      applyStimulus(4'b0001, 1'b1, 1'b0);
      if (obs_v) exp_cnt++;
      guard++;
    end
    checkOutput("t6_budget",  32'(exp_cnt),        32'd255);
    checkOutput("t6_cnt255",  32'(bus.served_cnt), 32'd255);
    guard = 0;
    obs_v = 1'b0;
    while (!obs_v && guard < 10) begin
      obs_v = bus.gnt_valid;
      applyStimulus(4'b0001, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("t6_budget2", 32'(obs_v),          32'h1);
    checkOutput("t6_wrap",    32'(bus.served_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
